// File: rtl/prom_pkg.sv
// Shared constants and types for the PROM microinstruction fetch path.
package prom_pkg;

    localparam int unsigned IWIDTH  = 49;
    localparam int unsigned AWIDTH  = 9;
    localparam int unsigned BWIDTH  = 16;
    localparam int unsigned NBEATS  = 4;
    localparam int unsigned RAWIDTH = AWIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        HIT,
        READ,
        DONE
    } state_t;

    typedef logic [1:0] beat_t;

    localparam beat_t LAST_BEAT = beat_t'(NBEATS - 1);

    // A correctly programmed microinstruction carries odd parity over all bits.
    function automatic logic odd_parity_ok(input logic [IWIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/prom_fetch_if.sv
// Signal bundle between the PROM address stage, the boot ROM and the IR-load path.
// Defining PROM_PARITY_EN adds the parity_err output.
interface prom_fetch_if;
    import prom_pkg::*;

    logic [AWIDTH-1:0]  promaddr;
    logic               promenable;
    logic               req;
    logic               flush;
    logic [RAWIDTH-1:0] rom_addr;
    logic               rom_rd;
    logic [BWIDTH-1:0]  rom_data;
    logic               rom_ack;
    logic [IWIDTH-1:0]  iprom;
    logic               iprom_valid;
    logic               busy;

`ifdef PROM_PARITY_EN
    logic               parity_err;

    modport slave (
        input  promaddr, promenable, req, flush, rom_data, rom_ack,
        output rom_addr, rom_rd, iprom, iprom_valid, busy, parity_err
    );

    modport master (
        output promaddr, promenable, req, flush, rom_data, rom_ack,
        input  rom_addr, rom_rd, iprom, iprom_valid, busy, parity_err
    );
`else
    modport slave (
        input  promaddr, promenable, req, flush, rom_data, rom_ack,
        output rom_addr, rom_rd, iprom, iprom_valid, busy
    );

    modport master (
        output promaddr, promenable, req, flush, rom_data, rom_ack,
        input  rom_addr, rom_rd, iprom, iprom_valid, busy
    );
`endif

endinterface

// File: rtl/prom_beat_asm.sv
// Merges 16-bit ROM beats into the 49-bit microinstruction buffer; bits past
// the top of the word are dropped, so the last beat contributes only its bit 0.
module prom_beat_asm
    import prom_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  beat_t             i_beat,
    input  logic [BWIDTH-1:0] i_data,
    input  logic              i_ack,
    output logic [IWIDTH-1:0] o_buf
);

    logic [IWIDTH-1:0] r_buf;
    logic [IWIDTH-1:0] w_shift;
    logic [IWIDTH-1:0] w_mask;
    logic [5:0]        w_shamt;

    always_comb begin
        w_shamt = 6'(32'(i_beat) * BWIDTH);
        w_shift = IWIDTH'(i_data) << w_shamt;
        w_mask  = IWIDTH'({BWIDTH{1'b1}}) << w_shamt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf <= '0;
        end else if (i_ack) begin
            r_buf <= (r_buf & ~w_mask) | w_shift;
        end
    end

    assign o_buf = r_buf;

endmodule

// File: rtl/prom_fetch.sv
// Fetches one microinstruction from the 16-bit boot ROM in four beats, with a
// one-entry last-address buffer for repeat fetches. Optional: PROM_PARITY_EN.
module prom_fetch
    import prom_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    prom_fetch_if.slave bus
);

    state_t             r_state;
    state_t             w_next;
    logic [AWIDTH-1:0]  r_word;
    beat_t              r_beat;
    logic               r_en_lost;
    logic [IWIDTH-1:0]  r_iprom;
    logic               r_last_valid;
    logic [AWIDTH-1:0]  r_last_addr;

    logic [IWIDTH-1:0]  w_buf;
    logic               w_hit;
    logic               w_start_read;
    logic               w_ack;
    logic               w_load;
    logic               w_par_ok;

    logic               w_rom_rd;
    logic [RAWIDTH-1:0] w_rom_addr;
    logic [IWIDTH-1:0]  w_iprom;
    logic               w_valid;
    logic               w_busy;

    // A flush arriving with the request forces a miss.
    assign w_hit        = bus.req && bus.promenable && r_last_valid && !bus.flush
                          && (bus.promaddr == r_last_addr);
    assign w_start_read = (r_state == IDLE) && bus.req && bus.promenable && !w_hit;
    assign w_ack        = (r_state == READ) && bus.rom_ack;
    assign w_load       = (r_state == DONE) && !r_en_lost;

`ifdef PROM_PARITY_EN
    assign w_par_ok = odd_parity_ok(w_buf);
`else
    assign w_par_ok = 1'b1;
`endif

    prom_beat_asm u_beat_asm (
        .clk     (clk),
        .reset_n (reset_n),
        .i_beat  (r_beat),
        .i_data  (bus.rom_data),
        .i_ack   (w_ack),
        .o_buf   (w_buf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.req && bus.promenable) begin
                    w_next = w_hit ? HIT : READ;
                end
            end
            HIT:  w_next = IDLE;
            READ: begin
                if (w_ack && (r_beat == LAST_BEAT)) begin
                    w_next = DONE;
                end
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_rom_rd   = (r_state == READ);
        w_rom_addr = w_rom_rd ? {r_word, r_beat} : '0;
        w_valid    = (r_state == HIT) || w_load;
        w_busy     = (r_state == READ) || (r_state == DONE);
        // The DONE cycle presents the assembled word directly so data and
        // valid coincide; the holding register takes it on the same edge.
        w_iprom    = w_load ? w_buf : r_iprom;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word       <= '0;
            r_beat       <= '0;
            r_en_lost    <= 1'b0;
            r_iprom      <= '0;
            r_last_valid <= 1'b0;
            r_last_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_read) begin
                        r_word    <= bus.promaddr;
                        r_beat    <= '0;
                        r_en_lost <= 1'b0;
                    end
                end
                READ: begin
                    if (!bus.promenable) begin
                        r_en_lost <= 1'b1;
                    end
                    if (w_ack) begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                DONE: begin
                    if (w_load) begin
                        r_iprom <= w_buf;
                    end
                end
                default: ;
            endcase

            // iprom may have changed under any completed read, so an unverified
            // or abandoned word always drops the buffer.
            if (bus.flush) begin
                r_last_valid <= 1'b0;
            end else if (r_state == DONE) begin
                if (w_load && w_par_ok) begin
                    r_last_valid <= 1'b1;
                    r_last_addr  <= r_word;
                end else begin
                    r_last_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.rom_rd      = w_rom_rd;
    assign bus.rom_addr    = w_rom_addr;
    assign bus.iprom       = w_iprom;
    assign bus.iprom_valid = w_valid;
    assign bus.busy        = w_busy;

`ifdef PROM_PARITY_EN
    assign bus.parity_err  = w_load && !w_par_ok;
`endif

endmodule

// File: tb/tb_prom_fetch.sv
// Directed plus randomized bench for prom_fetch against a transaction-level
// model of the last-address buffer and ROM word assembly.
module tb_prom_fetch;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    prom_fetch_if bus();

    prom_fetch dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [15:0] rom [0:2047];
    int unsigned ws = 0;
    int unsigned wcnt = 0;

    assign bus.rom_data = rom[bus.rom_addr];
    assign bus.rom_ack  = bus.rom_rd && (wcnt == ws);

    always @(posedge clk) begin
        wcnt <= (bus.rom_rd && !bus.rom_ack) ? wcnt + 1 : 0;
    end

    int unsigned nrd = 0;
    int unsigned stab_err = 0;
    logic [10:0] acked [$];
    logic        prev_rd = 1'b0;
    logic        prev_ack = 1'b0;
    logic [10:0] prev_addr = '0;

    always @(negedge clk) begin
        if (bus.rom_rd) begin
            nrd <= nrd + 1;
            if (bus.rom_ack) acked.push_back(bus.rom_addr);
            if (prev_rd && !prev_ack && (bus.rom_addr !== prev_addr)) stab_err <= stab_err + 1;
        end
        prev_rd   <= bus.rom_rd;
        prev_ack  <= bus.rom_ack;
        prev_addr <= bus.rom_addr;
    end

    int n_cmp = 0;
    int n_err = 0;

    logic        mlv = 1'b0;
    logic [8:0]  mla = '0;
    logic [48:0] miprom = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [8:0] a, input logic en, input logic fl,
                        input int drop_at, input logic fod);
        int          cyc;
        int          vcyc;
        int          exp_v;
        logic [48:0] viprom;
        logic        vpe;
        int          nrd0;
        int          q0;
        logic        done;
        logic        hit;
        logic        miss;
        logic        drop;
        logic [48:0] word;
        logic        pe;
        logic [10:0] ea;

        nrd0 = int'(nrd);
        q0 = acked.size();
        vcyc = -1;
        viprom = '0;
        vpe = 1'b0;

        @(negedge clk);
        bus.promaddr = a;
        bus.promenable = en;
        bus.req = 1'b1;
        bus.flush = fl;
        @(negedge clk);
        bus.req = 1'b0;
        bus.flush = 1'b0;
        cyc = 1;
        done = 1'b0;
        while (!done) begin
            if (bus.iprom_valid) begin
                vcyc = cyc;
                viprom = bus.iprom;
`ifdef PROM_PARITY_EN
                vpe = bus.parity_err;
`endif
                bus.flush = fod && bus.busy;
            end else begin
                bus.flush = 1'b0;
            end
            if (cyc == drop_at) bus.promenable = 1'b0;
            if (!bus.busy) begin
                done = 1'b1;
            end else if (cyc >= 80) begin
                check("timeout_busy", {63'd0, bus.busy}, 64'd0);
                bus.flush = 1'b0;
                done = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end

        word = {rom[{a, 2'd3}][0], rom[{a, 2'd2}], rom[{a, 2'd1}], rom[{a, 2'd0}]};
        pe = 1'b0;
`ifdef PROM_PARITY_EN
        pe = ~(^word);
`endif
        hit  = en && mlv && !fl && (a == mla);
        miss = en && !hit;
        drop = miss && (drop_at > 0);
        if (fl) mlv = 1'b0;
        exp_v = -1;

        if (hit) begin
            exp_v = 1;
            check("hit_no_rd", 64'(int'(nrd) - nrd0), 64'd0);
            check("hit_iprom", 64'(viprom), 64'(miprom));
            check("hit_perr", {63'd0, vpe}, 64'd0);
        end else if (miss) begin
            check("miss_rd_cycles", 64'(int'(nrd) - nrd0), 64'(4 * (ws + 1)));
            check("miss_beats", 64'(acked.size() - q0), 64'd4);
            if (acked.size() >= q0 + 4) begin
                for (int k = 0; k < 4; k++) begin
                    ea = {a, 2'(k)};
                    check("beat_addr", 64'(acked[q0 + k]), 64'(ea));
                end
            end
            if (drop) begin
                mlv = 1'b0;
            end else begin
                exp_v = 1 + 4 * int'(ws + 1);
                check("miss_iprom", 64'(viprom), 64'(word));
                check("miss_perr", {63'd0, vpe}, {63'd0, pe});
                miprom = word;
                mlv = !fod && !pe;
                mla = a;
            end
        end else begin
            check("ignored_no_rd", 64'(int'(nrd) - nrd0), 64'd0);
        end
        check("valid_cycle", 64'(vcyc), 64'(exp_v));
        check("iprom_hold", 64'(bus.iprom), 64'(miprom));
    endtask

    initial begin
        int q0;
        bus.promaddr = '0;
        bus.promenable = 1'b0;
        bus.req = 1'b0;
        bus.flush = 1'b0;
        for (int i = 0; i < 2048; i++) rom[i] = 16'($urandom);
        rom[20] = 16'h1234;
        rom[21] = 16'h5678;
        rom[22] = 16'h9ABC;
        rom[23] = 16'h0001;
        rom[39] = 16'hFFFE;
        rom[28] = 16'h0000;
        rom[29] = 16'h0000;
        rom[30] = 16'h0000;
        rom[31] = 16'h0000;

        repeat (3) @(negedge clk);
        check("rst_rd", {63'd0, bus.rom_rd}, 64'd0);
        check("rst_addr", 64'(bus.rom_addr), 64'd0);
        check("rst_iprom", 64'(bus.iprom), 64'd0);
        check("rst_valid", {63'd0, bus.iprom_valid}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
`ifdef PROM_PARITY_EN
        check("rst_perr", {63'd0, bus.parity_err}, 64'd0);
`endif
        reset_n = 1'b1;

        ws = 0;
        step(9'h005, 1'b1, 1'b0, 0, 1'b0);
        check("dir_word", 64'(bus.iprom), 64'(49'h1_9ABC_5678_1234));
        step(9'h005, 1'b1, 1'b0, 0, 1'b0);

        ws = 3;
        step(9'h009, 1'b1, 1'b0, 0, 1'b0);
        check("bit48_trunc", {63'd0, bus.iprom[48]}, 64'd0);

        ws = 0;
        step(9'h009, 1'b0, 1'b0, 0, 1'b0);
        step(9'h00A, 1'b1, 1'b0, 2, 1'b0);
        step(9'h00A, 1'b1, 1'b0, 0, 1'b0);
        step(9'h00A, 1'b1, 1'b0, 0, 1'b0);
        step(9'h00B, 1'b1, 1'b0, 0, 1'b1);
        step(9'h00B, 1'b1, 1'b0, 0, 1'b0);
        step(9'h00B, 1'b1, 1'b1, 0, 1'b0);

        ws = 3;
        q0 = acked.size();
        @(negedge clk);
        bus.promaddr = 9'h005;
        bus.promenable = 1'b1;
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        for (int i = 0; i < 40 && (acked.size() - q0) < 2; i++) @(negedge clk);
        check("rst_mid_beats", 64'(acked.size() - q0), 64'd2);
        #2 reset_n = 1'b0;
        #1;
        check("arst_rd", {63'd0, bus.rom_rd}, 64'd0);
        check("arst_addr", 64'(bus.rom_addr), 64'd0);
        check("arst_iprom", 64'(bus.iprom), 64'd0);
        check("arst_valid", {63'd0, bus.iprom_valid}, 64'd0);
        check("arst_busy", {63'd0, bus.busy}, 64'd0);
`ifdef PROM_PARITY_EN
        check("arst_perr", {63'd0, bus.parity_err}, 64'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mlv = 1'b0;
        miprom = '0;
        ws = 0;
        step(9'h005, 1'b1, 1'b0, 0, 1'b0);

`ifdef PROM_PARITY_EN
        step(9'h007, 1'b1, 1'b0, 0, 1'b0);
        step(9'h007, 1'b1, 1'b0, 0, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            ws = $urandom_range(0, 2);
            step(9'($urandom_range(0, 3)),
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) == 0,
                 ($urandom_range(0, 9) == 0) ? 2 : 0,
                 $urandom_range(0, 9) == 0);
        end

        check("addr_stable", 64'(stab_err), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
